jk_bank_arbiter: RTL
====================

Name: jk_bank_arbiter

Overview:
- Owns a WIDTH-bit bank of JK flip-flop cells. Each cell follows the standard JK rule: 00 hold, 01 clear, 10 set, 11 toggle.
- Two requesters share the bank. Each requester issues masked bank operations over a valid/ready handshake.
- The block arbitrates round-robin, decodes each command into per-bit J/K vectors, applies one operation at a time and acknowledges the winner.
- It sits between control logic and any JK-based state register in the design.

Parameters:
WIDTH, 8, number of JK cells in the bank (1..32)
CNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
req0_valid  input  1  requester 0 command valid
req0_op  input  2  requester 0 op: 00 HOLD, 01 CLEAR, 10 SET, 11 TOGGLE
req0_mask  input  WIDTH  requester 0 bit select; 1 = bit affected
req0_ready  output  1  requester 0 acknowledge, one-cycle pulse
req1_valid  input  1  requester 1 command valid
req1_op  input  2  requester 1 op, same encoding
req1_mask  input  WIDTH  requester 1 bit select
req1_ready  output  1  requester 1 acknowledge, one-cycle pulse
q  output  WIDTH  bank state
j_out  output  WIDTH  J vector applied to the bank
k_out  output  WIDTH  K vector applied to the bank
grant_id  output  1  requester currently being served (valid while busy)
busy  output  1  high in APPLY and DONE
op_count  output  CNT_W  completed operations, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, active-high), forced immediately and held while reset is high:
  - q=0, j_out=0, k_out=0, req0_ready=0, req1_ready=0, busy=0, grant_id=0, op_count=0.
  - FSM goes to IDLE; round-robin pointer set so requester 0 has priority.
- FSM states: IDLE, APPLY, DONE.
- IDLE:
  - busy=0 and j_out=k_out=0.
  - At a rising edge, if any reqN_valid=1, select the winner, latch its op and mask into internal registers, set grant_id, and go to APPLY.
  - No valid request: stay in IDLE.
- Arbitration:
  - Single valid requester wins.
  - If both are valid, the requester not granted last time wins.
  - Pointer updates to the winner at grant. After reset, requester 0 wins a tie.
- APPLY (one cycle):
  - j_out/k_out driven from the latched command, per bit: mask=0 gives J=K=0; mask=1 gives J=op[1], K=op[0].
  - At the rising edge ending APPLY, each q bit updates by the JK rule from j_out/k_out. State goes to DONE.
- DONE (one cycle):
  - reqN_ready=1 for the granted requester only; j_out=k_out=0; q already shows the new value.
  - At the edge ending DONE: handshake complete, op_count increments, state goes to IDLE.
- Latency and throughput:
  - Request sampled at edge E0; ready is high in the cycle after E1; q is updated from E1.
  - The earliest next grant is at edge E3, so throughput is one operation per 3 cycles.
- Requester obligations:
  - Hold valid, op and mask stable until ready is seen.
  - Deassert valid in the cycle after ready, unless issuing a new command.
  - A valid still high after a completed handshake counts as a new request.
- Payload changes after the IDLE capture are ignored for the in-flight operation.
- A requester dropping valid while granted does not abort the operation; DONE still pulses ready.
- HOLD, or mask=0: the full handshake still occurs, q is unchanged and op_count increments.
- op_count wraps from 2^CNT_W-1 to 0.
- Reset during APPLY or DONE:
  - The operation is aborted, q clears to 0 and no ready pulse is issued.
  - A request still valid after reset release is re-arbitrated from the reset priority.
- At most one ready is high in any cycle; ready never asserts while busy=0.

Test Plan:
- Assert reset, then release -> q=0x00, busy=0, both readys 0, op_count=0. Re-assert reset mid-idle -> outputs stay cleared.
- req0 SET mask=0x0F from q=0x00 -> j_out=0x0F and k_out=0x00 in APPLY; q=0x0F and req0_ready=1 for exactly one cycle in DONE; op_count=1.
- req1 TOGGLE mask=0xFF from q=0x0F -> j_out=k_out=0xFF in APPLY; q=0xF0; req1_ready pulse only; grant_id=1.
- Both valid from reset: req0 SET 0x01, req1 CLEAR 0x01, both held asserted -> grant order 0,1,0,1; q alternates 0x01,0x00; each grant 3 cycles apart.
- req0 HOLD mask=0xFF on q=0xA5 -> q stays 0xA5; ready pulses; op_count increments. Preload op_count to 0xFFFF with CNT_W=16 -> wraps to 0x0000.
- req0 SET 0xFF, assert reset during APPLY -> q=0x00, no req0_ready. Keep req0_valid high after release -> re-granted; q=0xFF after completion.

Source files
------------

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter for two requesters sharing a bank of JK cells.
// Each accepted command is applied in one cycle and acknowledged in the next.
module jk_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_mask,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_mask,
  output logic             req1_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             grant_id,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] mask_r;
  logic             last_r;
  logic             win;
  logic             grant;

  // Tie goes to whoever was not served last.
  always_comb begin
    win = req1_valid;
    if (req0_valid && req1_valid)
      win = ~last_r;
  end

  assign grant = (state == IDLE) &&
                 (req0_valid || req1_valid);

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    j_out      = '0;
    k_out      = '0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant)
          state_nxt = APPLY;
      end
      APPLY: begin
        busy      = 1'b1;
        j_out     = mask_r & {WIDTH{op_r[1]}};
        k_out     = mask_r & {WIDTH{op_r[0]}};
        state_nxt = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        req0_ready = ~grant_id;
        req1_ready = grant_id;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_r     <= '0;
      mask_r   <= '0;
      grant_id <= 1'b0;
      last_r   <= 1'b1;
      q        <= '0;
      op_count <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        op_r     <= win ? req1_op : req0_op;
        mask_r   <= win ? req1_mask : req0_mask;
        grant_id <= win;
        last_r   <= win;
      end
      if (state == APPLY)
        q <= (j_out & ~q) | (~k_out & q);
      if (state == DONE)
        op_count <= op_count + 1'b1;
    end
  end

endmodule
